// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker: sweeps a/b through all four vectors, samples the gates block after SETTLE cycles,
// and reports the verdict as a pass flag, a saturating error count and a sticky per-output fail mask.
module gate_sweep_checker #(
  parameter int SWEEPS = 1,
  parameter int SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic       and_in,
  input  logic       or_in,
  input  logic       not_in,
  input  logic       xor_in,
  input  logic       xnor_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic [4:0] err_mask
);
  typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;
  state_t state, state_nx;
  logic [3:0] settle_cnt;
  logic [7:0] sweep_cnt;
  logic [1:0] vec;
  logic [4:0] fail;
  logic       last_run;
  assign a = vec[1];
  assign b = vec[0];
  assign fail = {xnor_in, xor_in, not_in, or_in, and_in} ^ {~(a ^ b), a ^ b, ~a, a | b, a & b};
  assign last_run = vec == 2'b11 && sweep_cnt == 8'(SWEEPS - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? APPLY : IDLE;
      APPLY:   state_nx = settle_cnt == 4'(SETTLE - 1) ? CHECK : APPLY;
      CHECK:   state_nx = last_run ? DONE : APPLY;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    busy = state == APPLY || state == CHECK;
    done = state == DONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      settle_cnt <= '0;
      sweep_cnt  <= '0;
      vec        <= '0;
      pass       <= 1'b0;
      err_count  <= '0;
      err_mask   <= '0;
    end else case (state)
      IDLE: if (start) begin
        settle_cnt <= '0;
        sweep_cnt  <= '0;
        vec        <= '0;
        pass       <= 1'b0;
        err_count  <= '0;
        err_mask   <= '0;
      end
      APPLY: settle_cnt <= settle_cnt + 4'd1;
      CHECK: begin
        settle_cnt <= '0;
        // vec wraps 11 -> 00, which also parks a/b at 0 for DONE
        vec        <= vec + 2'd1;
        err_mask   <= err_mask | fail;
        if (|fail && err_count != 8'hff) err_count <= err_count + 8'd1;
        if (vec == 2'b11) sweep_cnt <= sweep_cnt + 8'd1;
        if (last_run) pass <= err_count == 8'd0 && fail == 5'd0;
      end
      default: ;
    endcase
endmodule
